// File: rtl/jbcd_pkg.sv
// Shared constants, FSM encoding and helpers
// for the BCD add/subtract datapath.
package jbcd_pkg;

  localparam logic [3:0] BCD_MAX   = 4'd9;
  localparam logic [4:0] BCD_RADIX = 5'd10;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic logic isbcd(input logic [3:0] n);
    return n <= BCD_MAX;
  endfunction

endpackage

// File: rtl/jbcddigitsub.sv
// Combinational single-digit BCD subtractor:
// digit = a_i - b_i - borrow_in, ten's-corrected.
module jbcddigitsub
  import jbcd_pkg::*;
(
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       borrow_in,
  output logic [3:0] digit,
  output logic       borrow_out
);

  logic [4:0] d;
  logic [4:0] adj;

  // d spans -16..15, so bit 4 is the sign in two's complement
  always_comb begin
    d          = {1'b0, a_i} - {1'b0, b_i} - {4'b0, borrow_in};
    adj        = d + BCD_RADIX;
    borrow_out = d[4];
    digit      = borrow_out ? adj[3:0] : d[3:0];
  end

endmodule

// File: rtl/jbcdsubserial.sv
// Digit-serial BCD subtractor, LSD first,
// with start/busy/done handshake.
module jbcdsubserial
  import jbcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic              borrowin,
  output logic              busy,
  output logic              done,
  output logic [4*DIGITS-1:0] y,
  output logic              borrowout,
  output logic              invalid
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t state_q, state_d;

  logic [W-1:0]  a_q, b_q, res_q;
  logic          brw_q, inv_q;
  logic [CW-1:0] cnt_q;

  logic [3:0] ai, bi, dig;
  logic       bo;
  logic       inv_in;
  logic       last;

  assign last = (cnt_q == CW'(DIGITS - 1));

  always_comb begin
    ai = '0;
    bi = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (cnt_q == CW'(i)) begin
        ai = a_q[4*i +: 4];
        bi = b_q[4*i +: 4];
      end
    end
  end

  always_comb begin
    inv_in = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!isbcd(a[4*i +: 4]) || !isbcd(b[4*i +: 4]))
        inv_in = 1'b1;
    end
  end

  jbcddigitsub u_dsub (
    .a_i       (ai),
    .b_i       (bi),
    .borrow_in (brw_q),
    .digit     (dig),
    .borrow_out(bo)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      brw_q <= 1'b0;
      inv_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            brw_q <= borrowin;
            inv_q <= inv_in;
            cnt_q <= '0;
            res_q <= '0;
          end
        end
        RUN: begin
          for (int i = 0; i < DIGITS; i++) begin
            if (cnt_q == CW'(i))
              res_q[4*i +: 4] <= dig;
          end
          brw_q <= bo;
          cnt_q <= cnt_q + CW'(1);
          // bad operands report a clean zero result
          if (last && inv_q) begin
            res_q <= '0;
            brw_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign y         = res_q;
  assign borrowout = brw_q;
  assign invalid   = inv_q;

endmodule

// File: tb/tb_jbcdsubserial.sv
// Self-checking bench for jbcdsubserial
// (DIGITS=4) using a result scoreboard.
module tb_jbcdsubserial;

  localparam int D = 4;

  typedef struct {
    logic [15:0] y;
    logic        bo;
    logic        inv;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        borrowin = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        busy, done, borrowout, invalid;
  logic [15:0] y;

  int   pass_n = 0;
  int   total_n = 0;
  int   cyc = 0;
  exp_t sb[$];

  jbcdsubserial #(.DIGITS(D)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .a        (a),
    .b        (b),
    .borrowin (borrowin),
    .busy     (busy),
    .done     (done),
    .y        (y),
    .borrowout(borrowout),
    .invalid  (invalid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic exp_t model(input logic [15:0] ma,
                                 input logic [15:0] mb,
                                 input logic mbin);
    exp_t e;
    int   av = 0;
    int   bv = 0;
    int   diff;
    bit   inv = 0;
    for (int i = 3; i >= 0; i--) begin
      if (int'(ma[4*i +: 4]) > 9) inv = 1;
      if (int'(mb[4*i +: 4]) > 9) inv = 1;
      av = av * 10 + int'(ma[4*i +: 4]);
      bv = bv * 10 + int'(mb[4*i +: 4]);
    end
    diff = av - bv - int'(mbin);
    e.bo = (diff < 0);
    if (diff < 0) diff += 10000;
    e.y = '0;
    for (int i = 0; i < 4; i++) begin
      e.y[4*i +: 4] = 4'(diff % 10);
      diff = diff / 10;
    end
    e.inv = inv;
    if (inv) begin
      e.y  = '0;
      e.bo = 1'b0;
    end
    return e;
  endfunction

  task automatic launch(input logic [15:0] ta,
                        input logic [15:0] tb_,
                        input logic tbin);
    a        = ta;
    b        = tb_;
    borrowin = tbin;
    start    = 1'b1;
    sb.push_back(model(ta, tb_, tbin));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int bc);
    lat = 0;
    bc  = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) bc++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total_n++;
    if ({busy, done, borrowout, invalid} !== 4'b0)
      $display("FAIL reset_ctl: got %b expected 0000",
               {busy, done, borrowout, invalid});
    else pass_n++;
    total_n++;
    if (y !== 16'h0)
      $display("FAIL reset_y: got %h expected 0000", y);
    else pass_n++;
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_zero();
    int   lat, bc;
    exp_t e;
    launch(16'h0000, 16'h0000, 1'b0);
    wait_done(lat, bc);
    total_n++;
    if (done !== 1'b1 || lat != D)
      $display("FAIL zero_latency: got %0d expected %0d", lat, D);
    else pass_n++;
    total_n++;
    if (bc != D)
      $display("FAIL zero_busy: got %0d expected %0d", bc, D);
    else pass_n++;
    e = sb.pop_front();
    total_n++;
    if (y !== e.y)
      $display("FAIL zero_y: got %h expected %h", y, e.y);
    else pass_n++;
    total_n++;
    if ({borrowout, invalid} !== {e.bo, e.inv})
      $display("FAIL zero_flags: got %b expected %b",
               {borrowout, invalid}, {e.bo, e.inv});
    else pass_n++;
    @(posedge clk); #1;
    total_n++;
    if (done !== 1'b0 || busy !== 1'b0)
      $display("FAIL zero_pulse: got done=%b busy=%b expected 0 0",
               done, busy);
    else pass_n++;
    total_n++;
    if (y !== e.y)
      $display("FAIL zero_hold: got %h expected %h", y, e.y);
    else pass_n++;
  endtask

  task automatic test_basic();
    logic [15:0] va[4] = '{16'h1234, 16'h0567, 16'h9999, 16'h5000};
    logic [15:0] vb[4] = '{16'h0567, 16'h1234, 16'h9999, 16'h0001};
    logic        vc[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    int   lat, bc;
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      launch(va[k], vb[k], vc[k]);
      wait_done(lat, bc);
      total_n++;
      if (done !== 1'b1 || lat != D)
        $display("FAIL basic%0d_latency: got %0d expected %0d",
                 k, lat, D);
      else pass_n++;
      e = sb.pop_front();
      total_n++;
      if (y !== e.y)
        $display("FAIL basic%0d_y: got %h expected %h", k, y, e.y);
      else pass_n++;
      total_n++;
      if ({borrowout, invalid} !== {e.bo, e.inv})
        $display("FAIL basic%0d_flags: got %b expected %b",
                 k, {borrowout, invalid}, {e.bo, e.inv});
      else pass_n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_invalid();
    int   lat, bc;
    exp_t e;
    launch(16'h12A4, 16'h0001, 1'b0);
    wait_done(lat, bc);
    total_n++;
    if (done !== 1'b1 || lat != D)
      $display("FAIL inv_latency: got %0d expected %0d", lat, D);
    else pass_n++;
    e = sb.pop_front();
    total_n++;
    if (invalid !== 1'b1)
      $display("FAIL inv_flag: got %b expected 1", invalid);
    else pass_n++;
    total_n++;
    if (y !== e.y)
      $display("FAIL inv_y: got %h expected %h", y, e.y);
    else pass_n++;
    total_n++;
    if (borrowout !== e.bo)
      $display("FAIL inv_bo: got %b expected %b", borrowout, e.bo);
    else pass_n++;
    @(posedge clk); #1;
  endtask

  task automatic test_restart_ignored();
    int   lat, bc, dn;
    exp_t e;
    launch(16'h0042, 16'h0013, 1'b0);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat, bc);
    total_n++;
    if (done !== 1'b1 || lat != D - 2)
      $display("FAIL restart_latency: got %0d expected %0d",
               lat, D - 2);
    else pass_n++;
    e = sb.pop_front();
    total_n++;
    if (y !== e.y)
      $display("FAIL restart_y: got %h expected %h", y, e.y);
    else pass_n++;
    dn = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) dn++;
    end
    total_n++;
    if (dn != 0)
      $display("FAIL restart_extra_done: got %0d expected 0", dn);
    else pass_n++;
  endtask

  task automatic test_reset_mid();
    int   lat, bc, dn;
    exp_t e;
    launch(16'h0999, 16'h0001, 1'b0);
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    total_n++;
    if ({busy, done} !== 2'b00)
      $display("FAIL rstmid_ctl: got %b expected 00", {busy, done});
    else pass_n++;
    total_n++;
    if (y !== 16'h0)
      $display("FAIL rstmid_y: got %h expected 0000", y);
    else pass_n++;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    dn = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) dn++;
    end
    total_n++;
    if (dn != 0)
      $display("FAIL rstmid_no_done: got %0d expected 0", dn);
    else pass_n++;
    launch(16'h0010, 16'h0001, 1'b0);
    wait_done(lat, bc);
    total_n++;
    if (done !== 1'b1 || lat != D)
      $display("FAIL rstmid_latency: got %0d expected %0d", lat, D);
    else pass_n++;
    e = sb.pop_front();
    total_n++;
    if (y !== e.y)
      $display("FAIL rstmid_y_after: got %h expected %h", y, e.y);
    else pass_n++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [15:0] va[3] = '{16'h0100, 16'h2500, 16'h0000};
    logic [15:0] vb[3] = '{16'h0001, 16'h2499, 16'h0001};
    int   t[3];
    int   lat, bc;
    exp_t e;
    a        = va[0];
    b        = vb[0];
    borrowin = 1'b0;
    start    = 1'b1;
    sb.push_back(model(va[0], vb[0], 1'b0));
    @(posedge clk); #1;
    for (int j = 0; j < 3; j++) begin
      wait_done(lat, bc);
      t[j] = cyc;
      total_n++;
      if (done !== 1'b1)
        $display("FAIL b2b%0d_timeout: got done=%b expected 1",
                 j, done);
      else pass_n++;
      e = sb.pop_front();
      total_n++;
      if (y !== e.y || borrowout !== e.bo)
        $display("FAIL b2b%0d_result: got %b_%h expected %b_%h",
                 j, borrowout, y, e.bo, e.y);
      else pass_n++;
      if (j < 2) begin
        a = va[j+1];
        b = vb[j+1];
        sb.push_back(model(va[j+1], vb[j+1], 1'b0));
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    for (int j = 0; j < 2; j++) begin
      total_n++;
      if (t[j+1] - t[j] != D + 2)
        $display("FAIL b2b_interval%0d: got %0d expected %0d",
                 j, t[j+1] - t[j], D + 2);
      else pass_n++;
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_basic();
    test_invalid();
    test_restart_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule

// File: doc/jbcdsubserial.md
Name: jbcdsubserial

Overview:
- Digit-serial, multi-digit BCD subtractor. Computes Y = A - B - borrowin on DIGITS packed BCD digits.
- Processes one digit per clock, least significant digit first.
- It is the inverse-direction companion of the team's combinational BCD adder. Together they form the BCD add/subtract path of the arithmetic lab datapath.
- Uses a start/busy/done handshake so a sequencer or testbench can launch operations back to back.

Parameters:
- DIGITS, 4: number of BCD digits in each operand. Legal range 1..8.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- start  in  1  launch request; sampled only in IDLE.
- a  in  4*DIGITS  minuend, packed BCD, digit 0 in bits [3:0].
- b  in  4*DIGITS  subtrahend, packed BCD.
- borrowin  in  1  borrow into digit 0.
- busy  out  1  high while digits are being processed (RUN).
- done  out  1  one-cycle pulse when y/borrowout/invalid become valid.
- y  out  4*DIGITS  packed BCD difference (ten's complement if the result is negative).
- borrowout  out  1  borrow out of the most significant digit.
- invalid  out  1  at least one input digit was greater than 9.

Behaviour:
- Reset: while rstn=0, all of the following are held 0 and the FSM is in IDLE: busy, done, y, borrowout, invalid, the digit counter, and the internal registers.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN on the edge where start=1.
  - On that edge: latch a, b and borrowin; clear the counter to 0; clear the working result.
  - Also on that edge: latch invalid = (any digit of a or b > 9).
- RUN: each edge processes digit i = counter.
  - d = a_i - b_i - borrow, using signed 5-bit arithmetic.
  - If d < 0: digit = d + 10, borrow = 1. Otherwise: digit = d, borrow = 0.
  - Write the digit into slot i of the working result; increment the counter.
  - After the edge that processes digit DIGITS-1, go to DONE.
- DONE: lasts exactly one cycle, then returns to IDLE.
  - done=1, busy=0.
  - y, borrowout and invalid are valid in this cycle.
  - They hold their values in IDLE until the next start edge.
- Latency: start sampled at edge k -> busy high for cycles k+1..k+DIGITS -> done high in cycle k+DIGITS+1. Total DIGITS+1 cycles.
- start is ignored in RUN and DONE. Operands changing on a/b during RUN have no effect.
- Invalid operands: the computation still runs with full timing. In the DONE cycle y is forced to 0 and borrowout to 0, with invalid=1.
- Each digit result is always in 0..9 for valid inputs. borrowout=1 means the true result is negative and y = 10^DIGITS + (A - B - borrowin).
- Reset mid-operation: the FSM is abandoned immediately.
  - Outputs clear asynchronously; no done is produced.
  - A new start is accepted on the first edge after rstn rises.
- start held continuously: a new operation launches on each return to IDLE, i.e. every DIGITS+2 cycles.

Decomposition:
- Package jbcd_pkg:
  - BCD_MAX = 4'd9, BCD_RADIX = 5'd10.
  - FSM state enum {IDLE, RUN, DONE}.
  - Digit-validity function isbcd(nibble).
- Sub-module jbcddigitsub: combinational single-digit subtractor. Inputs a_i, b_i, borrow_in; outputs digit, borrow_out.
  - It is instantiated once in the serial loop.
  - It is unit-testable in isolation, mirroring how the adder is tested.

Test Plan (DIGITS=4):
- a=0000, b=0000, borrowin=0, start 1 cycle -> done in cycle 5 after start; y=0000, borrowout=0, invalid=0; busy high for exactly 4 cycles.
- a=1234, b=0567, borrowin=0 -> y=0667, borrowout=0.
- a=0567, b=1234, borrowin=0 -> y=9333, borrowout=1.
- a=9999, b=9999, borrowin=1 -> y=9999, borrowout=1; then a=5000, b=0001 -> y=4999, borrowout=0 (borrow ripples across three digits).
- a=12A4 (digit 1 = 4'hA), b=0001 -> done after normal latency; invalid=1, y=0000, borrowout=0.
- Robustness:
  - start pulsed again during RUN -> ignored; exactly one done.
  - rstn dropped in cycle 2 of RUN -> busy, done and y go to 0 immediately; no done follows.
  - After rstn rises, a=0010, b=0001 -> y=0009.
